mips_data_sram_responder: RTL
=============================

Name: mips_data_sram_responder

Overview:
Responder for the core's data SRAM port (en / 4-bit byte write-enable / addr / wdata in, rdata out). It answers every access with fixed one-cycle read latency. It decodes each access to either a word-addressed local RAM or a small memory-mapped register block (LED, number display, switch input, free-running timer, scratch). It sits outside the CPU top and is the memory-side end of the data SRAM interface the core drives from its execute stage.

Parameters:
RAM_AW, 12, RAM depth is 2^RAM_AW 32-bit words; RAM index = data_sram_addr[RAM_AW+1:2]
MMIO_HI, 16'hBFAF, value of data_sram_addr[31:16] that selects the register block; every other value selects RAM
SW_W, 8, width of switch input

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
data_sram_en  input  1  access request this cycle
data_sram_wen  input  4  byte write enables; bit i writes wdata[8i+7:8i]; 0 = read
data_sram_addr  input  32  byte address; bits [1:0] ignored
data_sram_wdata  input  32  write data
data_sram_rdata  output  32  read data, registered
led_out  output  16  LED register
num_out  output  32  number-display register
sw_in  input  SW_W  switch levels (already synchronous to clk)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge.
- Reset values:
  - data_sram_rdata = 0, led_out = 0, num_out = 0, TIMER = 0, SCRATCH = 0.
  - RAM contents are not reset.
- Reset priority: rst=1 overrides a simultaneous request. No RAM or register write occurs, and rdata = 0 the next cycle.
- Accesses are accepted every cycle with no stall and no backpressure. Back-to-back accesses are fully pipelined.
- Read latency: if en=1 at edge N, data_sram_rdata holds the addressed word from edge N until edge N+1.
- en=0: data_sram_rdata holds its previous value; no state changes except TIMER.
- Write with en=1 and wen!=0:
  - Only enabled bytes are updated, at edge N.
  - Read-first: data_sram_rdata after edge N shows the pre-write word.
  - A read of the same address at edge N+1 returns the merged word.
- wen!=0 with en=0: ignored.
- Decode: register block selected when addr[31:16]==MMIO_HI; register offset is addr[15:0] with bits [1:0] ignored.
  - RAM addresses above the depth alias (modulo 2^RAM_AW words).
- Register map (offsets):
  - 0xF000 LED: read/write, bits [15:0]; upper wdata bytes ignored; reads zero-extended.
  - 0xF010 NUM: read/write, 32 bits.
  - 0xF020 SW: read-only. Reads {zeros, sw_in} sampled at the access edge. Writes ignored.
  - 0xF030 TIMER: 32-bit counter, +1 every cycle when not written; wraps 0xFFFFFFFF -> 0.
    - Write (byte-merged with the current value) loads the merged value at edge N, then increments from edge N+1.
    - Write wins over increment in the same cycle.
    - Read returns the value before edge N.
  - 0xF040 SCRATCH: read/write, 32 bits.
  - Any other offset in the block: reads 0, writes ignored.
- Byte enables apply to LED, NUM, TIMER and SCRATCH writes exactly as they do for RAM.
- Outputs led_out and num_out are direct register values, updated at the write edge.
- Not supported: X/unaligned detection, errors, interrupts.

Test Plan:
- Reset: hold rst 2 cycles with en=1, wen=4'hF, addr=0x100, wdata=0xDEADBEEF -> rdata=0, led_out=0, num_out=0. A later read of 0x100 does not return 0xDEADBEEF unless it was written after reset.
- RAM byte merge: write 0x11223344 @0x40 wen=F, then 0xAABBCCDD wen=4'b0101, then read -> third-cycle rdata shows 0x11223344 (read-first); read returns 0x11BB33DD.
- Back-to-back: writes to 0x0, 0x4, 0x8 on consecutive cycles, then reads 0x0, 0x4, 0x8 on consecutive cycles -> rdata matches each written value exactly one cycle after its request, with no gaps.
- Aliasing (RAM_AW=12): write 0xCAFEF00D @0x00004004, read @0x00000004 -> 0xCAFEF00D.
- MMIO: write 0xFFFF1234 to 0xBFAFF000 -> led_out=0x1234, read returns 0x00001234. sw_in=0xA5, read 0xBFAFF020 -> 0x000000A5. Write to 0xBFAFF020 has no effect. Read 0xBFAFF0F0 -> 0.
- Timer: write 0xFFFFFFFE to 0xBFAFF030 at edge N; read at edge N+1 -> 0xFFFFFFFE; read at edge N+2 -> 0xFFFFFFFF; read at edge N+3 -> 0x00000000 (wrap). Continuous increments are confirmed over 100 idle cycles.

Source files
------------

// File: rtl/mips_data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mips_data_sram_responder
//  Purpose  : Memory-side end of the core's data SRAM port. Answers every
//             access with a fixed one-cycle read latency. Decodes each access
//             to a word-addressed local RAM or to a small register block
//             (LED, number display, switches, free-running timer, scratch).
//  Revision : 1.0 - initial release
// ============================================================================
module mips_data_sram_responder #(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] MMIO_HI = 16'hBFAF,
    parameter int          SW_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data_sram_en,
    input  logic [3:0]      data_sram_wen,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic [31:0]     data_sram_rdata,
    output logic [15:0]     led_out,
    output logic [31:0]     num_out,
    input  logic [SW_W-1:0] sw_in
);

    localparam int          c_RAM_DEPTH = 1 << RAM_AW;

    // Register block offsets (byte offsets, word aligned)
    localparam logic [15:0] c_OFF_LED     = 16'hF000;
    localparam logic [15:0] c_OFF_NUM     = 16'hF010;
    localparam logic [15:0] c_OFF_SW      = 16'hF020;
    localparam logic [15:0] c_OFF_TIMER   = 16'hF030;
    localparam logic [15:0] c_OFF_SCRATCH = 16'hF040;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // Local RAM: not reset, contents undefined until written.
    logic [31:0] mem [c_RAM_DEPTH];

    logic [31:0] rdata_q,   rdata_d;
    logic [15:0] led_q,     led_d;
    logic [31:0] num_q,     num_d;
    logic [31:0] timer_q,   timer_d;
    logic [31:0] scratch_q, scratch_d;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic              w_is_mmio;
    logic [15:0]       w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr;
    logic              w_unused;

    // Address decode: upper half-word picks the register block, else RAM.
    // RAM addresses beyond the depth simply alias because only the low index
    // bits are used.
    always_comb begin
        w_is_mmio = (data_sram_addr[31:16] == MMIO_HI);
        w_off     = {data_sram_addr[15:2], 2'b00};
        w_ram_idx = data_sram_addr[RAM_AW+1:2];
        w_wr      = data_sram_en && (data_sram_wen != 4'b0000);
    end

    // Byte-lane bits of the address carry no information for word accesses.
    assign w_unused = &{1'b0, data_sram_addr[1:0]};

    // ------------------------------------------------------------------------
    // Read path: current contents of the addressed location
    // ------------------------------------------------------------------------
    logic [31:0] w_cur;

    // Read mux; this is the pre-write value, which is what a read-first
    // access returns and what a byte-masked write merges into.
    always_comb begin
        w_cur = 32'h0000_0000;
        if (w_is_mmio) begin
            case (w_off)
                c_OFF_LED:     w_cur = {16'h0000, led_q};
                c_OFF_NUM:     w_cur = num_q;
                c_OFF_SW:      w_cur = {{(32-SW_W){1'b0}}, sw_in};
                c_OFF_TIMER:   w_cur = timer_q;
                c_OFF_SCRATCH: w_cur = scratch_q;
                default:       w_cur = 32'h0000_0000;
            endcase
        end else begin
            w_cur = mem[w_ram_idx];
        end
    end

    // ------------------------------------------------------------------------
    // Byte merge of write data into the current word
    // ------------------------------------------------------------------------
    logic [31:0] w_merged;

    // Each enabled byte lane takes the write data, others keep the old value.
    always_comb begin
        w_merged = w_cur;
        for (int b = 0; b < 4; b++) begin
            if (data_sram_wen[b]) begin
                w_merged[8*b +: 8] = data_sram_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic for registers and read data
    // ------------------------------------------------------------------------
    // Register updates; timer free-runs unless written, and a write wins over
    // the increment in the same cycle.
    always_comb begin
        led_d     = led_q;
        num_d     = num_q;
        timer_d   = timer_q + 32'd1;
        scratch_d = scratch_q;
        rdata_d   = rdata_q;

        if (data_sram_en) begin
            rdata_d = w_cur;
        end

        if (w_wr && w_is_mmio) begin
            case (w_off)
                c_OFF_LED:     led_d     = w_merged[15:0];
                c_OFF_NUM:     num_d     = w_merged;
                c_OFF_TIMER:   timer_d   = w_merged;
                c_OFF_SCRATCH: scratch_d = w_merged;
                default:       ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // Register block and read-data flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= 32'h0000_0000;
            led_q     <= 16'h0000;
            num_q     <= 32'h0000_0000;
            timer_q   <= 32'h0000_0000;
            scratch_q <= 32'h0000_0000;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
        end
    end

    // RAM byte-lane writes; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && w_wr && !w_is_mmio) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b]) begin
                    mem[w_ram_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_sram_rdata = rdata_q;
    assign led_out         = led_q;
    assign num_out         = num_q;

endmodule
`default_nettype wire
